// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8-bit UART transmitter, LSB first, one stop bit. The send
//               request is level sensitive. It is re-armed only after send has
//               been seen low, so a held request launches exactly one frame.
//               Optional even parity is enabled by defining UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_uart_send,
  input  logic [31:0] io_uart_io_reg,
  output logic        io_uart_tx_busy,
  output logic        tx
);

  localparam int              c_BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_BW-1:0] c_BAUD_MAX = c_BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t          r_state,   w_state;
  logic [c_BW-1:0] r_baud,    w_baud;
  logic [2:0]      r_bit_cnt, w_bit_cnt;
  logic [7:0]      r_shift,   w_shift;
  logic            r_tx,      w_tx;
  logic            r_busy,    w_busy;
  logic            r_armed,   w_armed;
  logic            w_baud_done;
  logic            w_unused_upper;
`ifdef UART_TX_PARITY_EN
  logic            r_parity,  w_parity;
`endif

  // Upper register bits carry no meaning for the transmitter.
  assign w_unused_upper = ^io_uart_io_reg[31:8];

  // Last cycle of the current bit period.
  assign w_baud_done = (r_baud == c_BAUD_MAX);

  assign tx              = r_tx;
  assign io_uart_tx_busy = r_busy;

  // State and datapath registers; reset aborts any frame and forces idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_baud    <= w_baud;
      r_bit_cnt <= w_bit_cnt;
      r_shift   <= w_shift;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
      r_armed   <= w_armed;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity;
`endif
    end
  end

  // Next-state logic; tx/busy are computed one edge ahead so they leave as flops.
  always_comb begin
    w_state   = r_state;
    w_baud    = w_baud_done ? '0 : r_baud + 1'b1;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_tx      = r_tx;
    w_busy    = r_busy;
    // Any low sample of send re-arms, including during a frame.
    w_armed   = io_uart_send ? r_armed : 1'b1;
`ifdef UART_TX_PARITY_EN
    w_parity  = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_baud = '0;
        if (io_uart_send && r_armed) begin
          w_state   = S_START;
          w_shift   = io_uart_io_reg[7:0];
          w_bit_cnt = 3'd0;
          w_tx      = 1'b0;
          w_busy    = 1'b1;
          w_armed   = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_parity  = ^io_uart_io_reg[7:0];
`endif
        end
      end

      S_START: begin
        if (w_baud_done) begin
          w_state = S_DATA;
          w_tx    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state = S_PARITY;
            w_tx    = r_parity;
`else
            w_state = S_STOP;
            w_tx    = 1'b1;
`endif
          end else begin
            w_bit_cnt = r_bit_cnt + 3'd1;
            w_shift   = {1'b0, r_shift[7:1]};
            w_tx      = r_shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_state = S_STOP;
          w_tx    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_baud_done) begin
          w_state = S_IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end
      end

      default: begin
        w_state = S_IDLE;
        w_baud  = '0;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
